// File: rtl/key_ctrl_pkg.sv
// ============================================================================
//  Module      : key_ctrl_pkg
//  Description : Shared state encoding and default sizing for key_unlock_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package key_ctrl_pkg;

    localparam int KEY_SIZE_DEF = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        CHECK    = 3'd2,
        UNLOCKED = 3'd3,
        LOCKOUT  = 3'd4
    } key_state_t;

endpackage : key_ctrl_pkg

`default_nettype wire

// File: rtl/key_unlock_ctrl_if.sv
// ============================================================================
//  Module      : key_unlock_ctrl_if
//  Description : Key entry, increment gating and status bundle for key_unlock_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface key_unlock_ctrl_if #(
    parameter int FAIL_W = 2
);
    logic              key_start;
    logic              key_valid;
    logic              key_bit;
    logic              key_ready;
    logic              incr_req;
    logic              do_incr;
    logic              unlocked;
    logic              locked_out;
    logic [FAIL_W-1:0] fail_cnt;

    modport master (
        output key_start, key_valid, key_bit, incr_req,
        input  key_ready, do_incr, unlocked, locked_out, fail_cnt
    );

    modport slave (
        input  key_start, key_valid, key_bit, incr_req,
        output key_ready, do_incr, unlocked, locked_out, fail_cnt
    );

endinterface : key_unlock_ctrl_if

`default_nettype wire

// File: rtl/key_unlock_ctrl_lockout_timer.sv
// ============================================================================
//  Module      : lockout_timer
//  Description : Loadable down-counter; o_done is high in the cycle it reaches 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lockout_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;
    logic             r_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_count  <= i_load_val;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_count == '0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_done = r_active && (r_count == '0);

endmodule : lockout_timer

`default_nettype wire

// File: rtl/key_unlock_ctrl.sv
// ============================================================================
//  Module      : key_unlock_ctrl
//  Description : Serial key unlock sequencer gating counter increments; the
//                KEY_UNLOCK_LOCKOUT_EN macro builds failure counting and lockout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_unlock_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int                  KEY_SIZE       = KEY_SIZE_DEF,
    parameter logic [KEY_SIZE-1:0] KEY_VALUE      = KEY_SIZE'(4'hA),
    parameter int                  MAX_ATTEMPTS   = 3,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    key_unlock_ctrl_if.slave   bus
);

    localparam int                 c_CNT_W    = $clog2(KEY_SIZE + 1);
    localparam int                 c_FAIL_W   = $clog2(MAX_ATTEMPTS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(KEY_SIZE - 1);

    if (KEY_SIZE < 1) begin : g_bad_key_size
        $error("key_unlock_ctrl: KEY_SIZE must be at least 1");
    end
    if (MAX_ATTEMPTS < 1) begin : g_bad_max_attempts
        $error("key_unlock_ctrl: MAX_ATTEMPTS must be at least 1");
    end
    if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout_cycles
        $error("key_unlock_ctrl: LOCKOUT_CYCLES must be at least 1");
    end

    key_state_t          r_state;
    key_state_t          w_state_nxt;
    logic [KEY_SIZE-1:0] r_shift;
    logic [KEY_SIZE-1:0] w_shift_nxt;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_do_incr;
    logic                w_match;

`ifdef KEY_UNLOCK_LOCKOUT_EN
    localparam int                  c_TMR_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [c_TMR_W-1:0]  c_TMR_LOAD = c_TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [c_FAIL_W-1:0] c_MAX_FAIL = c_FAIL_W'(MAX_ATTEMPTS);

    logic [c_FAIL_W-1:0] r_fail_cnt;
    logic [c_FAIL_W-1:0] w_fail_nxt;
    logic [c_FAIL_W-1:0] w_fail_inc;
    logic                w_tmr_load;
    logic                w_tmr_done;

    assign w_fail_inc = (r_fail_cnt == c_MAX_FAIL) ? r_fail_cnt : r_fail_cnt + 1'b1;

    lockout_timer #(
        .WIDTH      (c_TMR_W)
    ) u_lockout_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (c_TMR_LOAD),
        .o_done     (w_tmr_done)
    );
`endif

    assign w_match = (r_shift == KEY_VALUE);

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_bit_cnt;
`ifdef KEY_UNLOCK_LOCKOUT_EN
        w_fail_nxt  = r_fail_cnt;
        w_tmr_load  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (bus.key_start) begin
                    w_state_nxt = LOAD;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            LOAD: begin
                // A restart request outranks a bit arriving in the same cycle.
                if (bus.key_start) begin
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (bus.key_valid) begin
                    w_shift_nxt = KEY_SIZE'({r_shift, bus.key_bit});
                    w_cnt_nxt   = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                if (w_match) begin
                    w_state_nxt = UNLOCKED;
`ifdef KEY_UNLOCK_LOCKOUT_EN
                    w_fail_nxt  = '0;
`endif
                end else begin
`ifdef KEY_UNLOCK_LOCKOUT_EN
                    w_fail_nxt = w_fail_inc;
                    if (w_fail_inc == c_MAX_FAIL) begin
                        w_state_nxt = LOCKOUT;
                        w_tmr_load  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
`else
                    w_state_nxt = IDLE;
`endif
                end
            end
            UNLOCKED: begin
                if (bus.key_start) begin
                    w_state_nxt = LOAD;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            LOCKOUT: begin
`ifdef KEY_UNLOCK_LOCKOUT_EN
                if (w_tmr_done) begin
                    w_state_nxt = IDLE;
                    w_fail_nxt  = '0;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_do_incr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_do_incr <= bus.incr_req && (r_state == UNLOCKED);
        end
    end

`ifdef KEY_UNLOCK_LOCKOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_cnt <= '0;
        end else begin
            r_fail_cnt <= w_fail_nxt;
        end
    end

    assign bus.locked_out = (r_state == LOCKOUT);
    assign bus.fail_cnt   = r_fail_cnt;
`else
    assign bus.locked_out = 1'b0;
    assign bus.fail_cnt   = {c_FAIL_W{1'b0}};
`endif

    assign bus.key_ready = (r_state == LOAD);
    assign bus.unlocked  = (r_state == UNLOCKED);
    assign bus.do_incr   = r_do_incr;

endmodule : key_unlock_ctrl

`default_nettype wire

// File: tb/tb_key_unlock_ctrl.sv
// ============================================================================
//  Module      : tb_key_unlock_ctrl
//  Description : Directed self-checking bench for key_unlock_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_unlock_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    key_unlock_ctrl_if #(.FAIL_W(2)) bus ();

    key_unlock_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.key_start = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_bit   = 1'b0;
        bus.incr_req  = 1'b0;
    endtask

    task automatic start_key();
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
    endtask

    // Leaves the DUT in CHECK once the last bit is taken.
    task automatic send_key(input logic [3:0] k);
        for (int i = 3; i >= 0; i--) begin
            bus.key_valid = 1'b1;
            bus.key_bit   = k[i];
            tick();
        end
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++; if (bus.key_ready !== 1'b0) begin n_fail++; $display("FAIL reset_key_ready got %b exp 0", bus.key_ready); end
        n_tests++; if (bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL reset_unlocked got %b exp 0", bus.unlocked); end
        n_tests++; if (bus.locked_out !== 1'b0) begin n_fail++; $display("FAIL reset_locked_out got %b exp 0", bus.locked_out); end
        n_tests++; if (bus.do_incr !== 1'b0) begin n_fail++; $display("FAIL reset_do_incr got %b exp 0", bus.do_incr); end
        n_tests++; if (bus.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_fail_cnt got %0d exp 0", bus.fail_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_correct_key();
        start_key();
        n_tests++; if (bus.key_ready !== 1'b1) begin n_fail++; $display("FAIL ck_key_ready got %b exp 1", bus.key_ready); end
        send_key(4'hA);
        n_tests++; if (bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL ck_check_unlocked got %b exp 0", bus.unlocked); end
        n_tests++; if (bus.key_ready !== 1'b0) begin n_fail++; $display("FAIL ck_check_key_ready got %b exp 0", bus.key_ready); end
        tick();
        n_tests++; if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL ck_unlocked got %b exp 1", bus.unlocked); end
        bus.incr_req = 1'b1;
        n_tests++; if (bus.do_incr !== 1'b0) begin n_fail++; $display("FAIL ck_incr_latency got %b exp 0", bus.do_incr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.do_incr !== 1'b1) begin n_fail++; $display("FAIL ck_do_incr[%0d] got %b exp 1", i, bus.do_incr); end
        end
        bus.incr_req = 1'b0;
        tick();
        n_tests++; if (bus.do_incr !== 1'b0) begin n_fail++; $display("FAIL ck_do_incr_end got %b exp 0", bus.do_incr); end
    endtask

    task automatic test_relock();
        bus.incr_req  = 1'b1;
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
        n_tests++; if (bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL rl_unlocked got %b exp 0", bus.unlocked); end
        n_tests++; if (bus.key_ready !== 1'b1) begin n_fail++; $display("FAIL rl_key_ready got %b exp 1", bus.key_ready); end
        tick();
        n_tests++; if (bus.do_incr !== 1'b0) begin n_fail++; $display("FAIL rl_do_incr got %b exp 0", bus.do_incr); end
        bus.incr_req = 1'b0;
    endtask

    task automatic test_restart_priority();
        bus.key_valid = 1'b1;
        bus.key_bit   = 1'b1;
        tick();
        tick();
        bus.key_start = 1'b1;
        bus.key_bit   = 1'b0;
        tick();
        bus.key_start = 1'b0;
        bus.key_bit = 1'b1; tick();
        bus.key_bit = 1'b0; tick();
        bus.key_bit = 1'b1; tick();
        n_tests++; if (bus.key_ready !== 1'b1) begin n_fail++; $display("FAIL rs_three_bits_ready got %b exp 1", bus.key_ready); end
        bus.key_bit = 1'b0; tick();
        bus.key_valid = 1'b0;
        n_tests++; if (bus.key_ready !== 1'b0) begin n_fail++; $display("FAIL rs_four_bits_ready got %b exp 0", bus.key_ready); end
        tick();
        n_tests++; if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL rs_unlocked got %b exp 1", bus.unlocked); end
    endtask

    task automatic test_valid_gaps();
        logic [6:0] vld;
        logic [6:0] bits;
        vld  = 7'b1010011;
        bits = 7'b1101110;
        start_key();
        for (int i = 6; i >= 0; i--) begin
            bus.key_valid = vld[i];
            bus.key_bit   = bits[i];
            tick();
            if (i > 0) begin
                n_tests++; if (bus.key_ready !== 1'b1) begin n_fail++; $display("FAIL gap_ready[%0d] got %b exp 1", i, bus.key_ready); end
            end
        end
        bus.key_valid = 1'b0;
        n_tests++; if (bus.key_ready !== 1'b0) begin n_fail++; $display("FAIL gap_check_ready got %b exp 0", bus.key_ready); end
        tick();
        n_tests++; if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL gap_unlocked got %b exp 1", bus.unlocked); end
    endtask

    task automatic test_reset_mid_load();
        start_key();
        bus.key_valid = 1'b1;
        bus.key_bit   = 1'b1;
        tick();
        tick();
        bus.key_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.key_ready !== 1'b0) begin n_fail++; $display("FAIL rml_key_ready got %b exp 0", bus.key_ready); end
        n_tests++; if (bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL rml_unlocked got %b exp 0", bus.unlocked); end
        n_tests++; if (bus.do_incr !== 1'b0) begin n_fail++; $display("FAIL rml_do_incr got %b exp 0", bus.do_incr); end
        tick();
        rst_n = 1'b1;
        tick();
        start_key();
        send_key(4'hA);
        tick();
        n_tests++; if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL rml_reentry_unlocked got %b exp 1", bus.unlocked); end
    endtask

`ifdef KEY_UNLOCK_LOCKOUT_EN
    task automatic test_lockout();
        for (int a = 1; a <= 3; a++) begin
            start_key();
            send_key(4'h5);
            tick();
            n_tests++; if (bus.fail_cnt !== 2'(a)) begin n_fail++; $display("FAIL lo_fail_cnt[%0d] got %0d exp %0d", a, bus.fail_cnt, a); end
            n_tests++; if (bus.locked_out !== (a == 3)) begin n_fail++; $display("FAIL lo_locked_out[%0d] got %b exp %b", a, bus.locked_out, (a == 3)); end
        end
        bus.incr_req  = 1'b1;
        bus.key_start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_tests++; if (bus.locked_out !== 1'b1) begin n_fail++; $display("FAIL lo_hold[%0d] got %b exp 1", i, bus.locked_out); end
            n_tests++; if (bus.do_incr !== 1'b0 || bus.key_ready !== 1'b0) begin n_fail++; $display("FAIL lo_ignored[%0d] do_incr %b key_ready %b exp 0 0", i, bus.do_incr, bus.key_ready); end
        end
        clear_inputs();
        tick();
        n_tests++; if (bus.locked_out !== 1'b0) begin n_fail++; $display("FAIL lo_exit got %b exp 0", bus.locked_out); end
        n_tests++; if (bus.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL lo_exit_fail_cnt got %0d exp 0", bus.fail_cnt); end
        n_tests++; if (bus.key_ready !== 1'b0) begin n_fail++; $display("FAIL lo_exit_idle got %b exp 0", bus.key_ready); end
        for (int a = 0; a < 3; a++) begin
            start_key();
            send_key(4'h5);
            tick();
        end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.locked_out !== 1'b0) begin n_fail++; $display("FAIL lo_reset_locked_out got %b exp 0", bus.locked_out); end
        n_tests++; if (bus.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL lo_reset_fail_cnt got %0d exp 0", bus.fail_cnt); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask
`else
    task automatic test_no_lockout();
        for (int a = 0; a < 5; a++) begin
            start_key();
            send_key(4'h5);
            tick();
            n_tests++; if (bus.locked_out !== 1'b0 || bus.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL nl_wrong[%0d] locked_out %b fail_cnt %0d exp 0 0", a, bus.locked_out, bus.fail_cnt); end
            n_tests++; if (bus.unlocked !== 1'b0 || bus.key_ready !== 1'b0) begin n_fail++; $display("FAIL nl_idle[%0d] unlocked %b key_ready %b exp 0 0", a, bus.unlocked, bus.key_ready); end
        end
        start_key();
        send_key(4'hA);
        tick();
        n_tests++; if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL nl_unlocked got %b exp 1", bus.unlocked); end
    endtask
`endif

    initial begin
        test_reset();
        test_correct_key();
        test_relock();
        test_restart_priority();
        test_valid_gaps();
        test_reset_mid_load();
`ifdef KEY_UNLOCK_LOCKOUT_EN
        test_lockout();
`else
        test_no_lockout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_key_unlock_ctrl

`default_nettype wire
